// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - bus bundle between multicycle_ctrl and its datapath and memories
//
// Purpose: groups every controller-facing signal of the 16-bit-instruction processor.
//          The master modport is the controller side, the slave modport is the
//          datapath/memory side.
// Ports (master view):
//   instr_addr  out PC_W     instruction address (= pc)
//   instr       in  16       instruction word, one cycle after instr_addr
//   rf_ra/rb/rc out 3        register read A / read B / write numbers
//   rf_re/we    out 1        register read / write strobes
//   rf_wdata    out DATA_W   register write data
//   rf_rdata_a/b in DATA_W   register read data, valid cycle after rf_re
//   alu_op      out 4        ALU function
//   alu_a/b     out DATA_W   ALU operands
//   alu_res     in  DATA_W   ALU result;  alu_flags in 4 {V,S,C,Z}
//   dm_addr     out DMEM_AW  data-memory address
//   dm_wdata    out DATA_W   data-memory write data
//   dm_rd/wr    out 1        data-memory strobes
//   dm_rdata    in  DATA_W   data-memory read data;  dm_ready in 1
//   sreg        out 4        status flags {V,S,C,Z}
//   halted      out 1        controller is in HALT
//   retired     out 1        one-cycle pulse per completed instruction
interface multicycle_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 7
);
    logic [PC_W-1:0]    instr_addr;
    logic [15:0]        instr;
    logic [2:0]         rf_ra;
    logic [2:0]         rf_rb;
    logic [2:0]         rf_rc;
    logic               rf_re;
    logic               rf_we;
    logic [DATA_W-1:0]  rf_wdata;
    logic [DATA_W-1:0]  rf_rdata_a;
    logic [DATA_W-1:0]  rf_rdata_b;
    logic [3:0]         alu_op;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_res;
    logic [3:0]         alu_flags;
    logic [DMEM_AW-1:0] dm_addr;
    logic [DATA_W-1:0]  dm_wdata;
    logic               dm_rd;
    logic               dm_wr;
    logic [DATA_W-1:0]  dm_rdata;
    logic               dm_ready;
    logic [3:0]         sreg;
    logic               halted;
    logic               retired;

    modport master (
        output instr_addr, rf_ra, rf_rb, rf_rc, rf_re, rf_we, rf_wdata,
               alu_op, alu_a, alu_b, dm_addr, dm_wdata, dm_rd, dm_wr,
               sreg, halted, retired,
        input  instr, rf_rdata_a, rf_rdata_b, alu_res, alu_flags,
               dm_rdata, dm_ready
    );

    modport slave (
        input  instr_addr, rf_ra, rf_rb, rf_rc, rf_re, rf_we, rf_wdata,
               alu_op, alu_a, alu_b, dm_addr, dm_wdata, dm_rd, dm_wr,
               sreg, halted, retired,
        output instr, rf_rdata_a, rf_rdata_b, alu_res, alu_flags,
               dm_rdata, dm_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control unit for the 16-bit-instruction processor
//
// Purpose: owns pc, ir and the status flags and sequences register file, ALU,
//          data memory and instruction memory one instruction at a time.
// Ports:
//   clk  in  system clock, all state on rising edge
//   rst  in  synchronous active-high reset
//   bus  multicycle_ctrl_if.master, see the interface file for the signal list
module multicycle_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 7
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, READ, LATCH, EXEC, MEM, WB, NEXT, HALT
    } stateT;

    typedef enum logic [2:0] {
        KIND_ALU, KIND_LDI, KIND_MOVR, KIND_LD, KIND_ST, KIND_MOV, KIND_BR
    } kindT;

    function automatic kindT classify(input logic [15:0] w);
        kindT k;
        k = KIND_ALU;
        case (w[15:14])
            2'b00: k = KIND_ALU;
            2'b01: begin
                case (w[13:12])
                    2'b00:   k = KIND_LDI;
                    2'b01:   k = KIND_MOVR;
                    2'b10:   k = KIND_LD;
                    default: k = KIND_ST;
                endcase
            end
            2'b10:   k = KIND_BR;
            default: k = KIND_MOV;
        endcase
        return k;
    endfunction

    stateT              state, nextState;
    logic [PC_W-1:0]    pc;
    logic [15:0]        ir;
    logic [3:0]         sreg;
    logic [DATA_W-1:0]  rfWdata;
    logic [DATA_W-1:0]  dmWdata;
    logic [DMEM_AW-1:0] dmAddr;
    logic [DATA_W-1:0]  aluA, aluB;
    logic               memPhase;   // MOV only: 0 = read source, 1 = write destination

    logic               rfRe, rfWe, dmRd, dmWr;
    logic [2:0]         ra, rb, rc;
    logic               taken;

    // In DECODE the fresh word is still on bus.instr; ir only holds it from the next cycle on.
    kindT instrKind, irKind;
    assign instrKind = classify(bus.instr);
    assign irKind    = classify(ir);

    // Branch condition: sub-op 1000 is unconditional, 0xx0/0xx1 test sreg[xx] set/clear.
    always_comb begin
        taken = 1'b0;
        if (irKind == KIND_BR) begin
            if (ir[13:10] == 4'b1000) begin
                taken = 1'b1;
            end else if (!ir[13]) begin
                taken = sreg[ir[12:11]] ^ ir[10];
            end
        end
    end

    always_comb begin
        ra = 3'd0;
        rb = 3'd0;
        rc = 3'd0;
        case (irKind)
            KIND_ALU: begin
                ra = ir[9:7];
                rb = ir[6:4];
                rc = ir[3:1];
            end
            KIND_LDI:  rc = ir[2:0];
            KIND_MOVR: begin
                rc = ir[9:7];
                ra = ir[6:4];
            end
            KIND_LD: begin
                rb = ir[9:7];
                rc = ir[6:4];
            end
            KIND_ST:   ra = ir[2:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        rfRe      = 1'b0;
        rfWe      = 1'b0;
        dmRd      = 1'b0;
        dmWr      = 1'b0;
        case (state)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (instrKind)
                    KIND_LDI: nextState = WB;
                    KIND_MOV: nextState = MEM;
                    KIND_BR:  nextState = (bus.instr[13:10] == 4'b1111) ? HALT : NEXT;
                    default:  nextState = READ;
                endcase
            end
            READ: begin
                rfRe      = 1'b1;
                nextState = LATCH;
            end
            LATCH: begin
                case (irKind)
                    KIND_ALU:  nextState = EXEC;
                    KIND_MOVR: nextState = WB;
                    default:   nextState = MEM;
                endcase
            end
            EXEC: nextState = WB;
            MEM: begin
                // Strobe and address stay put until dm_ready closes the access.
                dmRd = (irKind == KIND_LD) || ((irKind == KIND_MOV) && !memPhase);
                dmWr = (irKind == KIND_ST) || ((irKind == KIND_MOV) && memPhase);
                if (bus.dm_ready) begin
                    if (irKind == KIND_LD) begin
                        nextState = WB;
                    end else if ((irKind == KIND_MOV) && !memPhase) begin
                        nextState = MEM;
                    end else begin
                        nextState = NEXT;
                    end
                end
            end
            WB: begin
                rfWe      = 1'b1;
                nextState = NEXT;
            end
            NEXT:    nextState = FETCH;
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            sreg     <= '0;
            rfWdata  <= '0;
            dmWdata  <= '0;
            dmAddr   <= '0;
            aluA     <= '0;
            aluB     <= '0;
            memPhase <= 1'b0;
        end else begin
            case (state)
                DECODE: begin
                    ir <= bus.instr;
                    case (instrKind)
                        KIND_LDI: rfWdata <= DATA_W'(bus.instr[10:3]);
                        KIND_ST:  dmAddr  <= DMEM_AW'(bus.instr[9:3]);
                        KIND_MOV: dmAddr  <= DMEM_AW'(bus.instr[13:7]);
                        default: ;
                    endcase
                end
                LATCH: begin
                    case (irKind)
                        KIND_ALU: begin
                            aluA <= bus.rf_rdata_a;
                            aluB <= bus.rf_rdata_b;
                        end
                        KIND_MOVR: rfWdata <= bus.rf_rdata_a;
                        KIND_LD:   dmAddr  <= DMEM_AW'(bus.rf_rdata_b);
                        KIND_ST:   dmWdata <= bus.rf_rdata_a;
                        default: ;
                    endcase
                end
                EXEC: rfWdata <= bus.alu_res;
                MEM: begin
                    if (bus.dm_ready) begin
                        if (irKind == KIND_LD) begin
                            rfWdata <= bus.dm_rdata;
                        end else if ((irKind == KIND_MOV) && !memPhase) begin
                            dmWdata  <= bus.dm_rdata;
                            dmAddr   <= DMEM_AW'(ir[6:0]);
                            memPhase <= 1'b1;
                        end else begin
                            memPhase <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (irKind == KIND_ALU) begin
                        sreg <= bus.alu_flags;
                    end
                end
                NEXT: pc <= taken ? PC_W'(ir[9:2]) : pc + PC_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.instr_addr = pc;
    assign bus.rf_ra      = ra;
    assign bus.rf_rb      = rb;
    assign bus.rf_rc      = rc;
    assign bus.rf_re      = rfRe;
    assign bus.rf_we      = rfWe;
    assign bus.rf_wdata   = rfWdata;
    assign bus.alu_op     = ir[13:10];
    assign bus.alu_a      = aluA;
    assign bus.alu_b      = aluB;
    assign bus.dm_addr    = dmAddr;
    assign bus.dm_wdata   = dmWdata;
    assign bus.dm_rd      = dmRd;
    assign bus.dm_wr      = dmWr;
    assign bus.sreg       = sreg;
    assign bus.halted     = (state == HALT);
    assign bus.retired    = (state == NEXT);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.DATA_W(8), .PC_W(8), .DMEM_AW(7)) bus ();
    multicycle_ctrl_if #(.DATA_W(8), .PC_W(4), .DMEM_AW(7)) bus4 ();

    multicycle_ctrl #(.DATA_W(8), .PC_W(8), .DMEM_AW(7)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    multicycle_ctrl #(.DATA_W(8), .PC_W(4), .DMEM_AW(7)) dut4 (
        .clk(clk), .rst(rst4), .bus(bus4)
    );

    // Environment for the 8-bit-PC instance.
    logic [15:0] imem [256];
    logic [7:0]  regs [8];
    logic [8:0]  sum9;

    always @(posedge clk) bus.instr <= imem[bus.instr_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else begin
            if (bus.rf_re) begin
                bus.rf_rdata_a <= regs[bus.rf_ra];
                bus.rf_rdata_b <= regs[bus.rf_rb];
            end
            if (bus.rf_we) regs[bus.rf_rc] <= bus.rf_wdata;
        end
    end

    always_comb begin
        sum9          = 9'd0;
        bus.alu_flags = 4'd0;
        case (bus.alu_op)
            4'd0:    sum9 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'd1:    sum9 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            default: sum9 = {1'b0, bus.alu_a & bus.alu_b};
        endcase
        bus.alu_res      = sum9[7:0];
        bus.alu_flags[0] = (sum9[7:0] == 8'h00);
        bus.alu_flags[1] = sum9[8];
        bus.alu_flags[2] = sum9[7];
        bus.alu_flags[3] = (bus.alu_op == 4'd0)
                         ? ((bus.alu_a[7] == bus.alu_b[7]) && (sum9[7] != bus.alu_a[7]))
                         : ((bus.alu_a[7] != bus.alu_b[7]) && (sum9[7] != bus.alu_a[7]));
    end

    assign bus.dm_rdata = (bus.dm_addr == 7'h05) ? 8'hA7 : 8'h3C;

    // Environment for the 4-bit-PC instance: only branches execute there.
    logic [15:0] imem4 [16];
    always @(posedge clk) bus4.instr <= imem4[bus4.instr_addr];
    assign bus4.rf_rdata_a = 8'h00;
    assign bus4.rf_rdata_b = 8'h00;
    assign bus4.alu_res    = 8'h00;
    assign bus4.alu_flags  = 4'h0;
    assign bus4.dm_rdata   = 8'h00;
    assign bus4.dm_ready   = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'hA400;
        for (int i = 0; i < 16; i++) imem4[i] = 16'hA400;
        imem[0]      = 16'hC082;   // MOV 0x01 -> 0x02
        rst          = 1'b1;
        rst4         = 1'b1;
        bus.dm_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;

        // Reset state
        chk("rst_pc",     32'(bus.instr_addr), 0);
        chk("rst_dmaddr", 32'(bus.dm_addr), 0);
        chk("rst_rfwd",   32'(bus.rf_wdata), 0);
        chk("rst_dmwd",   32'(bus.dm_wdata), 0);
        chk("rst_alua",   32'(bus.alu_a), 0);
        chk("rst_alub",   32'(bus.alu_b), 0);
        chk("rst_sreg",   32'(bus.sreg), 0);
        chk("rst_strb",   32'({bus.rf_re, bus.rf_we, bus.dm_rd, bus.dm_wr, bus.halted, bus.retired}), 0);

        // MOV stalls in MEM with dm_ready low, then reset is applied mid-wait
        bus.dm_ready = 1'b0;
        tick(); tick();
        chk("mem_rd",   32'({bus.dm_rd, bus.dm_wr}), 2);
        chk("mem_src",  32'(bus.dm_addr), 1);
        tick(); tick();
        chk("wait_rd",  32'({bus.dm_rd, bus.dm_wr}), 2);
        chk("wait_src", 32'(bus.dm_addr), 1);

        imem[8'h00] = 16'h42D2;    // LDI r2,#0x5A
        imem[8'h01] = 16'h401B;    // LDI r3,#0x03
        imem[8'h02] = 16'h0138;    // ADD r2,r3 -> r4
        imem[8'h03] = 16'h0492;    // SUB r1,r1 -> r1
        imem[8'h04] = 16'h8080;    // BZS 0x20
        imem[8'h20] = 16'h43BD;    // LDI r5,#0x77
        imem[8'h21] = 16'h8500;    // BZC 0x40
        imem[8'h22] = 16'h7085;    // ST r5 -> 0x10
        imem[8'h23] = 16'hC286;    // MOV 0x05 -> 0x06
        imem[8'h24] = 16'hBC00;    // HALT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dm_ready = 1'b1;
        cyc = 1;
        chk("mrst_rd",     32'(bus.dm_rd), 0);
        chk("mrst_pc",     32'(bus.instr_addr), 0);
        chk("mrst_sreg",   32'(bus.sreg), 0);
        chk("mrst_dmaddr", 32'(bus.dm_addr), 0);

        // LDI, LDI, ADD
        while (cyc <= 15) begin
            chk("retire_seq", 32'(bus.retired), 32'((cyc == 4) || (cyc == 8) || (cyc == 15)));
            if (cyc == 3) begin
                chk("ldi_we",  32'(bus.rf_we), 1);
                chk("ldi_rc",  32'(bus.rf_rc), 2);
                chk("ldi_wd",  32'(bus.rf_wdata), 32'h5A);
            end
            if (cyc == 13) begin
                chk("add_a",   32'(bus.alu_a), 32'h5A);
                chk("add_b",   32'(bus.alu_b), 32'h03);
            end
            if (cyc == 14) begin
                chk("add_we",  32'(bus.rf_we), 1);
                chk("add_rc",  32'(bus.rf_rc), 4);
                chk("add_wd",  32'(bus.rf_wdata), 32'h5D);
            end
            tick();
        end

        // SUB to zero, then taken ZS branch
        while (cyc < 23) tick();
        chk("sub_sreg", 32'(bus.sreg), 32'h1);
        chk("br_pc",    32'(bus.instr_addr), 32'h04);
        tick(); tick();
        chk("br_ret",   32'(bus.retired), 1);
        tick();
        chk("br_taken", 32'(bus.instr_addr), 32'h20);

        // ZC with Z set falls through
        while (cyc < 33) tick();
        chk("zc_fall",  32'(bus.instr_addr), 32'h22);

        // ST with three dm_ready wait cycles
        bus.dm_ready = 1'b0;
        while (cyc <= 41) begin
            if (cyc == 40) bus.dm_ready = 1'b1;
            chk("st_wr",  32'(bus.dm_wr), 32'((cyc >= 37) && (cyc <= 40)));
            chk("st_rd",  32'(bus.dm_rd), 0);
            chk("st_ret", 32'(bus.retired), 32'(cyc == 41));
            if ((cyc >= 37) && (cyc <= 40)) begin
                chk("st_addr", 32'(bus.dm_addr), 32'h10);
                chk("st_data", 32'(bus.dm_wdata), 32'h77);
            end
            tick();
        end

        // MOV 0x05 -> 0x06
        while (cyc <= 46) begin
            chk("mov_ret", 32'(bus.retired), 32'(cyc == 46));
            if (cyc == 44) begin
                chk("mov_rd",   32'({bus.dm_rd, bus.dm_wr}), 2);
                chk("mov_src",  32'(bus.dm_addr), 32'h05);
            end
            if (cyc == 45) begin
                chk("mov_wr",   32'({bus.dm_rd, bus.dm_wr}), 1);
                chk("mov_dst",  32'(bus.dm_addr), 32'h06);
                chk("mov_data", 32'(bus.dm_wdata), 32'hA7);
            end
            tick();
        end
        while (cyc < 49) tick();
        chk("m_halt",   32'(bus.halted), 1);
        chk("m_haltpc", 32'(bus.instr_addr), 32'h24);

        // 4-bit PC: branch to 0xF, NOP wraps to 0, NOP, then HALT at 1
        imem4[0] = 16'hA03C;       // B 0x0F
        imem4[1] = 16'hBC00;       // HALT
        rst4 = 1'b0;
        cyc = 1;
        while (cyc <= 31) begin
            if (cyc == 4) begin
                chk("w_pcF", 32'(bus4.instr_addr), 32'hF);
                imem4[0] = 16'hA400;
            end
            if (cyc == 6)  chk("w_ret",  32'(bus4.retired), 1);
            if (cyc == 7)  chk("w_wrap", 32'(bus4.instr_addr), 0);
            if (cyc == 10) chk("w_pc1",  32'(bus4.instr_addr), 1);
            if (cyc >= 12) begin
                chk("h_halted", 32'(bus4.halted), 1);
                chk("h_pc",     32'(bus4.instr_addr), 1);
                chk("h_ret",    32'(bus4.retired), 0);
            end
            tick();
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("h_rst_halted", 32'(bus4.halted), 0);
        chk("h_rst_pc",     32'(bus4.instr_addr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
